eth_multi_timer: RTL and testbench
==================================

ETH_MULTI_TIMER -- requirements
Module: eth_multi_timer

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent timer channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 32, counter/period width (8..32).
REQ-003 SHALL have parameter RST_PERIOD, default 2999, reset value of every channel's PERIOD and counter.
REQ-004 SHALL have port clk  input  1  clock; reset reset_n, asynchronous, active-low.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port address  input  ADDR_W=$clog2(N_CH+1)+2  word address; bits [ADDR_W-1:2] select channel (index N_CH = global block), bits [1:0] select register.
REQ-007 SHALL have port chipselect  input  1  slave select.
REQ-008 SHALL have port write_n  input  1  active-low write strobe.
REQ-009 SHALL have port writedata  input  32  write data.
REQ-010 SHALL have port readdata  output  32  registered read data.
REQ-011 SHALL have port irq  output  N_CH  per-channel interrupt, level.

Function
REQ-012 SHALL map per-channel words: 0 CTRL, 1 PERIOD, 2 COUNT (read-only, live counter), 3 STATUS (bit0 TO, write-1-to-clear).
REQ-013 SHALL define CTRL bits: [0] IE, [1] CONT, [2] START (write strobe, reads 0), [3] STOP (write strobe, reads 0), [4] RUNNING (read-only).
REQ-014 SHALL map global words: 0 IRQ_PEND (read-only, bit i = irq[i]), 1 PRESCALE (PRESC_W=16 bits); words 2-3 read 0, writes ignored.
REQ-015 SHALL present readdata one cycle after chipselect with write_n high; unmapped/upper bits read 0; reads have no side effects.
REQ-016 SHALL decrement a running channel's counter on each tick; at tick with counter==0: reload PERIOD, set TO, clear RUNNING if CONT=0.
REQ-017 SHALL set TO only on a running zero-tick, never on counter idle at 0.
REQ-018 SHALL, on PERIOD write, clear RUNNING and load counter with new PERIOD on the following cycle.
REQ-019 SHALL treat PERIOD=0 as tick-rate timeout: TO sets on every tick while running.
REQ-020 SHALL give priority STOP > START when both set in one CTRL write; START while running has no effect on counter.
REQ-021 SHALL give TO set priority over same-cycle STATUS W1C clear.
REQ-022 SHALL drive irq[i] = TO[i] & IE[i], combinational from registers.
REQ-023 SHALL truncate writedata to CNT_W for PERIOD; COUNT and PERIOD read zero-extended.

Reset
REQ-024 SHALL on reset: counters and PERIOD = RST_PERIOD, CTRL = 0, RUNNING = 0, TO = 0, PRESCALE = 0, readdata = 0, irq = 0.
REQ-025 SHALL abort any count instantly on reset assertion; no TO generated on release.

Configuration
REQ-026 SHALL with ETH_TIMER_PRESCALER_EN defined: shared prescaler counter produces one tick every PRESCALE+1 clocks, restarted on PRESCALE write.
REQ-027 SHALL without ETH_TIMER_PRESCALER_EN: tick every clk, PRESCALE reads 0, writes ignored.

Structure
REQ-028 SHALL place register offsets, CTRL bit positions, PRESC_W in package eth_timer_pkg.
REQ-029 SHALL implement one channel in sub-module eth_timer_channel, instantiated N_CH times via generate.

Verification
REQ-030 Reset, read ch0 PERIOD -> 2999; COUNT -> 2999; CTRL -> 0; irq=0.
REQ-031 ch1 PERIOD=5, CTRL=0x7 -> TO at 6th tick after start, then every 6 ticks; irq[1]=1 until STATUS write 0x1.
REQ-032 ch2 PERIOD=3, CTRL=0x5 (one-shot) -> single TO, RUNNING=0 afterwards, COUNT=3.
REQ-033 PRESCALE=9 (macro on), ch0 PERIOD=1 running continuous -> TO every 20 clocks; macro off -> every 2 clocks.
REQ-034 STATUS W1C in same cycle as zero-tick -> TO stays 1; CTRL=0xC -> channel stopped.
REQ-035 PERIOD write mid-count -> RUNNING=0, COUNT=new value next cycle; IRQ_PEND reflects all pending irq bits.

Source files
------------

// File: rtl/eth_timer_pkg.sv
// Shared definitions for the multi-channel timer: register offsets, CTRL/STATUS
// bit positions, prescaler width and the per-channel run state.
package eth_timer_pkg;

    localparam int PRESC_W = 16;

    // Per-channel word offsets
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // Global block word offsets
    localparam logic [1:0] GREG_IRQ_PEND = 2'd0;
    localparam logic [1:0] GREG_PRESCALE = 2'd1;

    localparam int CTRL_IE      = 0;
    localparam int CTRL_CONT    = 1;
    localparam int CTRL_START   = 2;
    localparam int CTRL_STOP    = 3;
    localparam int CTRL_RUNNING = 4;
    localparam int STATUS_TO    = 0;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

endpackage

// File: rtl/eth_timer_channel.sv
// One down-counting timer channel: reload on zero-tick, sticky TO flag with
// write-1-to-clear, one-shot or continuous mode. Run state exported on state_o.
module eth_timer_channel
    import eth_timer_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int RST_PERIOD = 2999
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick_i,
    input  logic             ctrl_we_i,
    input  logic             period_we_i,
    input  logic             status_we_i,
    input  logic [31:0]      wdata_i,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] period_o,
    output logic             ie_o,
    output logic             cont_o,
    output logic             to_o,
    output logic             irq_o,
    output ch_state_e        state_o
);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             to_q, to_d;
    logic             ie_q, ie_d;
    logic             cont_q, cont_d;
    logic             to_set;

    // Tick processing first; register writes then override state and counter,
    // while a zero-tick set of TO always wins over a same-cycle clear.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        to_d     = to_q;
        ie_d     = ie_q;
        cont_d   = cont_q;
        to_set   = 1'b0;

        if (state_q == CH_RUN && tick_i) begin
            if (cnt_q == '0) begin
                cnt_d  = period_q;
                to_set = 1'b1;
                if (!cont_q) begin
                    state_d = CH_IDLE;
                end
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        if (ctrl_we_i) begin
            ie_d   = wdata_i[CTRL_IE];
            cont_d = wdata_i[CTRL_CONT];
            if (wdata_i[CTRL_STOP]) begin
                state_d = CH_IDLE;
            end else if (wdata_i[CTRL_START]) begin
                state_d = CH_RUN;
            end
        end

        if (period_we_i) begin
            period_d = wdata_i[CNT_W-1:0];
            cnt_d    = wdata_i[CNT_W-1:0];
            state_d  = CH_IDLE;
        end

        if (status_we_i && wdata_i[STATUS_TO]) begin
            to_d = 1'b0;
        end
        if (to_set) begin
            to_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= CH_IDLE;
            cnt_q    <= CNT_W'(RST_PERIOD);
            period_q <= CNT_W'(RST_PERIOD);
            to_q     <= 1'b0;
            ie_q     <= 1'b0;
            cont_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            to_q     <= to_d;
            ie_q     <= ie_d;
            cont_q   <= cont_d;
        end
    end

    assign count_o  = cnt_q;
    assign period_o = period_q;
    assign ie_o     = ie_q;
    assign cont_o   = cont_q;
    assign to_o     = to_q;
    assign irq_o    = to_q & ie_q;
    assign state_o  = state_q;

endmodule

// File: rtl/eth_multi_timer.sv
// N_CH-channel timer with a register slave port and level interrupts.
// Define ETH_TIMER_PRESCALER_EN to enable the shared PRESCALE tick divider.
module eth_multi_timer
    import eth_timer_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int CNT_W      = 32,
    parameter int RST_PERIOD = 2999,
    localparam int ADDR_W    = $clog2(N_CH + 1) + 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [N_CH-1:0]   irq
);

    localparam int CH_W = ADDR_W - 2;

    logic [CH_W-1:0] ch_sel;
    logic [1:0]      reg_sel;
    logic            bus_wr;
    logic            bus_rd;
    logic            global_sel;
    logic            tick;
    logic [31:0]     presc_rd;
    logic [31:0]     readdata_q, readdata_d;

    logic [CNT_W-1:0] ch_count  [N_CH];
    logic [CNT_W-1:0] ch_period [N_CH];
    ch_state_e        ch_state  [N_CH];
    logic [N_CH-1:0]  ch_ie;
    logic [N_CH-1:0]  ch_cont;
    logic [N_CH-1:0]  ch_to;
    logic [N_CH-1:0]  ch_running;

    assign ch_sel     = address[ADDR_W-1:2];
    assign reg_sel    = address[1:0];
    assign bus_wr     = chipselect & ~write_n;
    assign bus_rd     = chipselect & write_n;
    assign global_sel = (ch_sel == CH_W'(N_CH));

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic ch_hit;
        assign ch_hit = bus_wr && (ch_sel == CH_W'(gi));

        eth_timer_channel #(
            .CNT_W      (CNT_W),
            .RST_PERIOD (RST_PERIOD)
        ) u_channel (
            .clk         (clk),
            .reset_n     (reset_n),
            .tick_i      (tick),
            .ctrl_we_i   (ch_hit && reg_sel == REG_CTRL),
            .period_we_i (ch_hit && reg_sel == REG_PERIOD),
            .status_we_i (ch_hit && reg_sel == REG_STATUS),
            .wdata_i     (writedata),
            .count_o     (ch_count[gi]),
            .period_o    (ch_period[gi]),
            .ie_o        (ch_ie[gi]),
            .cont_o      (ch_cont[gi]),
            .to_o        (ch_to[gi]),
            .irq_o       (irq[gi]),
            .state_o     (ch_state[gi])
        );

        assign ch_running[gi] = (ch_state[gi] == CH_RUN);
    end

`ifdef ETH_TIMER_PRESCALER_EN
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic               presc_we;

    assign presc_we = bus_wr && global_sel && (reg_sel == GREG_PRESCALE);
    assign tick     = (pcnt_q == presc_q);
    assign presc_rd = 32'(presc_q);

    // A PRESCALE write restarts the divider so the new rate applies cleanly.
    always_comb begin
        presc_d = presc_q;
        pcnt_d  = tick ? '0 : pcnt_q + PRESC_W'(1);
        if (presc_we) begin
            presc_d = writedata[PRESC_W-1:0];
            pcnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            pcnt_q  <= '0;
        end else begin
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
        end
    end
`else
    assign tick     = 1'b1;
    assign presc_rd = '0;
`endif

    always_comb begin
        readdata_d = '0;
        if (global_sel) begin
            case (reg_sel)
                GREG_IRQ_PEND: readdata_d = 32'(irq);
                GREG_PRESCALE: readdata_d = presc_rd;
                default:       readdata_d = '0;
            endcase
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (ch_sel == CH_W'(i)) begin
                    case (reg_sel)
                        REG_CTRL: begin
                            readdata_d[CTRL_IE]      = ch_ie[i];
                            readdata_d[CTRL_CONT]    = ch_cont[i];
                            readdata_d[CTRL_RUNNING] = ch_running[i];
                        end
                        REG_PERIOD: readdata_d = 32'(ch_period[i]);
                        REG_COUNT:  readdata_d = 32'(ch_count[i]);
                        default:    readdata_d[STATUS_TO] = ch_to[i];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= '0;
        end else if (bus_rd) begin
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;

endmodule

// File: tb/tb_eth_multi_timer.sv
// Self-checking bench for eth_multi_timer: directed scenarios plus random bus
// traffic, checked against a behavioural register/timer model.
module tb_eth_multi_timer;

    localparam int N_CH = 4;
    localparam int AW   = 5;
    localparam int RSTP = 2999;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [N_CH-1:0] irq;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    eth_multi_timer #(
        .N_CH       (N_CH),
        .CNT_W      (32),
        .RST_PERIOD (RSTP)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_cnt [N_CH];
    logic [31:0] m_per [N_CH];
    bit          m_run [N_CH];
    bit          m_to  [N_CH];
    bit          m_ie  [N_CH];
    bit          m_cont[N_CH];
    int unsigned m_presc;
    int unsigned m_since;

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_cnt[i] = RSTP; m_per[i] = RSTP;
            m_run[i] = 0; m_to[i] = 0; m_ie[i] = 0; m_cont[i] = 0;
        end
        m_presc = 0;
        m_since = 0;
        exp_q.delete();
    endtask

    function automatic logic [31:0] m_irq_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < N_CH; i++) v[i] = m_to[i] & m_ie[i];
        return v;
    endfunction

    function automatic logic [31:0] model_read(input int ch, input int rg);
        logic [31:0] v = '0;
        if (ch < N_CH) begin
            case (rg)
                0: begin v[0] = m_ie[ch]; v[1] = m_cont[ch]; v[4] = m_run[ch]; end
                1: v = m_per[ch];
                2: v = m_cnt[ch];
                default: v[0] = m_to[ch];
            endcase
        end else if (ch == N_CH) begin
            if (rg == 0) v = m_irq_vec();
            else if (rg == 1) v = m_presc;
        end
        return v;
    endfunction

    // One clock edge of behaviour: reads see the pre-edge state.
    task automatic model_step(input bit cs, input bit wn, input logic [AW-1:0] a, input logic [31:0] d);
        int ch = int'(a[4:2]);
        int rg = int'(a[1:0]);
        bit wr = cs && !wn;
        bit tick;
        bit set [N_CH];
        if (cs && wn) exp_q.push_back(model_read(ch, rg));
`ifdef ETH_TIMER_PRESCALER_EN
        tick = (m_since % (m_presc + 1)) == m_presc;
        if (wr && ch == N_CH && rg == 1) begin
            m_presc = d & 32'h0000_FFFF;
            m_since = 0;
        end else begin
            m_since++;
        end
`else
        tick = 1'b1;
`endif
        for (int i = 0; i < N_CH; i++) begin
            set[i] = 0;
            if (m_run[i] && tick) begin
                if (m_cnt[i] == 0) begin
                    m_cnt[i] = m_per[i];
                    set[i] = 1;
                    if (!m_cont[i]) m_run[i] = 0;
                end else begin
                    m_cnt[i] = m_cnt[i] - 1;
                end
            end
            if (wr && ch == i) begin
                case (rg)
                    0: begin
                        m_ie[i] = d[0]; m_cont[i] = d[1];
                        if (d[3]) m_run[i] = 0;
                        else if (d[2]) m_run[i] = 1;
                    end
                    1: begin m_per[i] = d; m_cnt[i] = d; m_run[i] = 0; end
                    3: if (d[0]) m_to[i] = 0;
                    default: ;
                endcase
            end
            if (set[i]) m_to[i] = 1;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_cycle(input bit cs, input bit wn, input logic [AW-1:0] a, input logic [31:0] d);
        logic [31:0] e;
        chipselect = cs; write_n = wn; address = a; writedata = d;
        @(posedge clk);
        model_step(cs, wn, a, d);
        #1;
        check("irq", 32'(irq), m_irq_vec());
        if (cs && wn) begin
            if (exp_q.size() == 0) begin
                check("rd_queue_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rdata", readdata, e);
            end
        end
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    function automatic logic [AW-1:0] ra(input int ch, input int rg);
        return AW'(ch * 4 + rg);
    endfunction

    task automatic bus_wr(input int ch, input int rg, input logic [31:0] d);
        do_cycle(1'b1, 1'b0, ra(ch, rg), d);
    endtask

    task automatic bus_rd(input int ch, input int rg, output logic [31:0] d);
        do_cycle(1'b1, 1'b1, ra(ch, rg), 32'd0);
        d = readdata;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b1, '0, 32'd0);
    endtask

    task automatic wait_irq(input int b, input int limit, output int k);
        k = 0;
        while (!irq[b] && k < limit) begin
            idle(1);
            k++;
        end
        if (!irq[b]) k = -1;
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] rv;
    int k;
    int exp_p;

    initial begin
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_rdata", readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset values
        bus_rd(0, 1, rv); check("rst_period", rv, 32'd2999);
        bus_rd(0, 2, rv); check("rst_count", rv, 32'd2999);
        bus_rd(0, 0, rv); check("rst_ctrl", rv, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);

        // Continuous channel 1, period 5: TO every 6 ticks
        bus_wr(1, 1, 32'd5);
        bus_wr(1, 0, 32'h7);
        wait_irq(1, 50, k); check("ch1_first_to", k, 32'd6);
        bus_wr(1, 3, 32'h1);
        check("ch1_irq_cleared", 32'(irq[1]), 32'd0);
        wait_irq(1, 50, k); check("ch1_second_to", k, 32'd5);
        bus_wr(1, 0, 32'h8);
        bus_wr(1, 3, 32'h1);

        // One-shot channel 2, period 3
        bus_wr(2, 1, 32'd3);
        bus_wr(2, 0, 32'h5);
        wait_irq(2, 50, k); check("ch2_oneshot_to", k, 32'd4);
        idle(3);
        bus_rd(2, 0, rv); check("ch2_ctrl_stopped", rv, 32'h1);
        bus_rd(2, 2, rv); check("ch2_count_reload", rv, 32'd3);
        bus_rd(2, 3, rv); check("ch2_status", rv, 32'h1);
        bus_wr(2, 3, 32'h1);

        // Tick rate: ch0 period 1
`ifdef ETH_TIMER_PRESCALER_EN
        bus_wr(4, 1, 32'd9);
        exp_p = 20;
        bus_rd(4, 1, rv); check("prescale_rd", rv, 32'd9);
`else
        bus_wr(4, 1, 32'd9);
        exp_p = 2;
        bus_rd(4, 1, rv); check("prescale_rd", rv, 32'd0);
`endif
        bus_wr(0, 1, 32'd1);
        bus_wr(0, 0, 32'h7);
        wait_irq(0, 100, k);
        bus_wr(0, 3, 32'h1);
        wait_irq(0, 100, k); check("ch0_to_interval", k, exp_p - 1);
        bus_wr(0, 0, 32'h8);
        bus_wr(0, 3, 32'h1);
        bus_wr(4, 1, 32'd0);

        // W1C collides with zero-tick: set wins
        bus_wr(3, 1, 32'd2);
        bus_wr(3, 0, 32'h7);
        wait_irq(3, 50, k); check("ch3_first_to", k, 32'd3);
        idle(2);
        bus_wr(3, 3, 32'h1);
        check("w1c_vs_set", 32'(irq[3]), 32'd1);
        bus_wr(3, 0, 32'hC);
        bus_rd(3, 0, rv); check("stop_over_start", rv, 32'd0);
        bus_wr(3, 3, 32'h1);

        // PERIOD write mid-count
        bus_wr(1, 1, 32'd100);
        bus_wr(1, 0, 32'h7);
        idle(10);
        bus_wr(1, 1, 32'd50);
        bus_rd(1, 0, rv); check("period_wr_stops", rv, 32'h3);
        bus_rd(1, 2, rv); check("period_wr_count", rv, 32'd50);

        // PERIOD=0 one-shots on ch0 and ch2 -> IRQ_PEND = 0x5
        bus_wr(0, 1, 32'd0);
        bus_wr(0, 0, 32'h5);
        bus_wr(2, 1, 32'd0);
        bus_wr(2, 0, 32'h5);
        idle(3);
        bus_rd(4, 0, rv); check("irq_pend", rv, 32'h5);
        bus_rd(4, 2, rv); check("global_w2_zero", rv, 32'd0);
        for (int i = 0; i < N_CH; i++) bus_wr(i, 3, 32'h1);

        // Random traffic
        for (int n = 0; n < 2400; n++) begin
            int op = $urandom_range(0, 9);
            int ch = $urandom_range(0, 7);
            int rg = $urandom_range(0, 3);
            logic [31:0] d;
            if (op <= 3) begin
                idle(1);
            end else if (op <= 6) begin
                do_cycle(1'b1, 1'b1, ra(ch, rg), 32'd0);
            end else begin
                if (ch > N_CH && $urandom_range(0, 1) == 0) ch = N_CH;
                if (ch == N_CH) d = ($urandom & 32'hFFFF_0000) | $urandom_range(0, 3);
                else if (rg == 0) d = $urandom_range(0, 31);
                else if (rg == 1) d = $urandom_range(0, 6);
                else d = $urandom;
                do_cycle(1'b1, 1'b0, ra(ch, rg), d);
            end

            // Asynchronous reset in the middle of traffic
            if (n == 1200) begin
                #2;
                reset_n = 1'b0;
                #1;
                check("async_rst_irq", 32'(irq), 32'd0);
                check("async_rst_rdata", readdata, 32'd0);
                model_reset();
                @(negedge clk);
                reset_n = 1'b1;
                bus_rd(1, 2, rv); check("post_rst_count", rv, 32'd2999);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
